reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//  Integer register file with the writeback handshake port that consumes the ALU's
//  reg_wr_data / reg_wr_addr / reg_wr_data_valid and returns reg_wr_ack.
//  Provides two combinational read ports (with optional write-bypass) for decode/issue.
//  Holds a per-register busy scoreboard so issue can stall on RAW hazards.
// PARAMETERS
//  XLEN      32  data width of each register
//  NUM_REGS  32  number of architectural registers; x0 is hardwired to zero
//  ADDR_W    5   register address width; must satisfy 2**ADDR_W == NUM_REGS
//  BYPASS    1   1 = read ports forward an accepted-this-cycle write; 0 = no forwarding
// PORTS
//  clk                input   1       clock; all state updates on the rising edge
//  reset              input   1       synchronous, active-high reset
//  reg_wr_data        input   XLEN    writeback data from ALU
//  reg_wr_addr        input   ADDR_W  writeback destination register
//  reg_wr_data_valid  input   1       writeback request; held by ALU until ack is seen
//  reg_wr_ack         output  1       one-cycle pulse: write committed
//  rs1_addr           input   ADDR_W  read port 1 address
//  rs1_data           output  XLEN    read port 1 data (combinational)
//  rs1_busy           output  1       rs1_addr has an outstanding locked write
//  rs2_addr           input   ADDR_W  read port 2 address
//  rs2_data           output  XLEN    read port 2 data (combinational)
//  rs2_busy           output  1       rs2_addr has an outstanding locked write
//  lock_valid         input   1       issue stage marks lock_addr as pending a write
//  lock_addr          input   ADDR_W  register to mark busy
// BEHAVIOUR
//  Reset: all registers = 0, busy mask = 0, reg_wr_ack = 0, FSM = IDLE.
//  Reset on the same edge as a request: reset wins, no write, no ack.
//  FSM states: IDLE, ACK.
//   IDLE: reg_wr_data_valid=1 at the edge -> write regs[reg_wr_addr], clear busy[reg_wr_addr],
//         reg_wr_ack<=1, go to ACK. Latency: ack is high in the cycle after valid is sampled.
//   ACK:  reg_wr_ack<=0, go to IDLE. reg_wr_data_valid is ignored in this cycle, because the
//         ALU drops valid on the edge where it samples ack. Back-to-back writes are therefore
//         one every 2 cycles.
//  x0 handling:
//   - a write to x0 is acked with the normal timing, but the array is not modified;
//   - rs*_data reads 0 for address 0;
//   - a lock of x0 is ignored, and rs*_busy is always 0 for address 0.
//  Read ports are combinational: rs*_data = regs[rs*_addr].
//  Bypass (BYPASS=1) applies when all of the following hold:
//   - FSM is IDLE and reg_wr_data_valid=1;
//   - reg_wr_addr equals rs*_addr;
//   - the address is nonzero.
//   In that case rs*_data = reg_wr_data.
//  Scoreboard:
//   - lock_valid=1 sets busy[lock_addr] at the edge;
//   - a committed write clears busy[reg_wr_addr];
//   - a lock and a commit to the same address on the same edge leave busy = 1 (a new
//     producer has issued);
//   - rs*_busy = busy[rs*_addr] (registered mask, no bypass of the lock).
//  A commit to an unlocked register is legal; busy stays 0.
//  A second lock of an already-busy register keeps it busy (single bit, no count).
//  Widths: all data is XLEN; no sign or zero extension is performed here.
// TESTING
//  1. Reset for 3 cycles -> reg_wr_ack=0, rs1_data=rs2_data=0 for every address, all busy=0.
//  2. valid=1, addr=5, data=32'h2 -> ack=1 on the next cycle only; afterwards rs1_addr=5
//     reads 32'h2.
//  3. Hold valid=1 across the ACK cycle (addr=6, data=7) -> exactly one ack per 2 cycles;
//     x6 = 7.
//  4. Write addr=0, data=32'hFFFF_FFFF -> ack pulses; rs1_addr=0 reads 0.
//  5. lock_valid=1, lock_addr=9 -> rs2_busy=1 for rs2_addr=9. Then write x9 = 32'h4
//     -> busy=0 the cycle after the commit, and rs2_data=4.
//  6. Same-edge lock x3 and commit x3 -> x3 is updated, busy[3] stays 1. Bypass case:
//     IDLE, valid=1, addr=3, data=32'hA, rs1_addr=3 -> rs1_data=32'hA in the same cycle.

Source files
------------

// File: rtl/reg_file_wb.sv
// Integer register file with a writeback handshake port.
// There are two combinational read ports with optional write forwarding.
// A per-register busy scoreboard lets the issue stage stall on RAW hazards.
// Register x0 always reads zero, ignores writes and is never marked busy.
module reg_file_wb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   reg_wr_data,
  input  logic [ADDR_W-1:0] reg_wr_addr,
  input  logic              reg_wr_data_valid,
  output logic              reg_wr_ack,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic              rs1_busy,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs2_busy,
  input  logic              lock_valid,
  input  logic [ADDR_W-1:0] lock_addr
);

  // ACK is a one-cycle dead slot. The ALU is still holding valid in that
  // cycle, and it drops valid on the edge where it samples the ack.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic   ack_reg, ack_next;
  logic   commit;

  // Per-register storage and busy bits. Each bit is owned by its own
  // generate block and gathered onto these nets.
  logic [XLEN-1:0]     reg_value [NUM_REGS];
  logic [NUM_REGS-1:0] busy_mask;

  // Handshake next-state logic: accept a write only from IDLE.
  always_comb begin
    state_next = state_reg;
    ack_next   = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (reg_wr_data_valid) begin
          commit     = 1'b1;
          ack_next   = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake state and ack registers. Reset overrides a same-edge request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
    end
  end

  assign reg_wr_ack = ack_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_value[gi] = '0;
        assign busy_mask[gi] = 1'b0;
      end else begin : g_arch
        logic [XLEN-1:0] value_reg;
        logic            busy_reg;
        logic            hit_wr;
        logic            hit_lock;

        assign hit_wr   = commit && (reg_wr_addr == ADDR_W'(gi));
        assign hit_lock = lock_valid && (lock_addr == ADDR_W'(gi));

        // Register contents: load on a committed write to this index.
        always_ff @(posedge clk) begin
          if (reset) begin
            value_reg <= '0;
          end else if (hit_wr) begin
            value_reg <= reg_wr_data;
          end
        end

        // Busy bit: a lock sets it, and a commit clears it. A same-edge lock
        // wins because it marks a newer producer.
        always_ff @(posedge clk) begin
          if (reset) begin
            busy_reg <= 1'b0;
          end else if (hit_lock) begin
            busy_reg <= 1'b1;
          end else if (hit_wr) begin
            busy_reg <= 1'b0;
          end
        end

        assign reg_value[gi] = value_reg;
        assign busy_mask[gi] = busy_reg;
      end
    end
  endgenerate

  // Forwarding is qualified exactly like a commit, so a request that is held
  // through the ACK dead slot is never forwarded.
  logic fwd_ok;
  assign fwd_ok = (BYPASS != 0) && (state_reg == IDLE) && reg_wr_data_valid;

  // Read port 1: forward a write accepted this cycle, or read the array.
  always_comb begin
    rs1_data = reg_value[rs1_addr];
    if (fwd_ok && (reg_wr_addr == rs1_addr) && (rs1_addr != '0)) begin
      rs1_data = reg_wr_data;
    end
  end

  // Read port 2: forward a write accepted this cycle, or read the array.
  always_comb begin
    rs2_data = reg_value[rs2_addr];
    if (fwd_ok && (reg_wr_addr == rs2_addr) && (rs2_addr != '0)) begin
      rs2_data = reg_wr_data;
    end
  end

  // The busy outputs show the registered mask only. A lock in flight is not
  // forwarded to them.
  assign rs1_busy = busy_mask[rs1_addr];
  assign rs2_busy = busy_mask[rs2_addr];

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb.
// Each issued write pushes the cycle in which its ack must appear.
// A negedge monitor pops one entry per ack it observes and checks the timing.
// The stimulus process checks read-port and busy values directly.
module tb_reg_file_wb;
  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [XLEN-1:0] reg_wr_data;
  logic [AW-1:0] reg_wr_addr;
  logic          reg_wr_data_valid;
  logic          reg_wr_ack;
  logic [AW-1:0] rs1_addr;
  logic [XLEN-1:0] rs1_data;
  logic          rs1_busy;
  logic [AW-1:0] rs2_addr;
  logic [XLEN-1:0] rs2_data;
  logic          rs2_busy;
  logic          lock_valid;
  logic [AW-1:0] lock_addr;

  reg_file_wb #(.XLEN(XLEN), .NUM_REGS(NR), .ADDR_W(AW), .BYPASS(1)) dut (
    .clk(clk),
    .reset(reset),
    .reg_wr_data(reg_wr_data),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data_valid(reg_wr_data_valid),
    .reg_wr_ack(reg_wr_ack),
    .rs1_addr(rs1_addr),
    .rs1_data(rs1_data),
    .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr),
    .rs2_data(rs2_data),
    .rs2_busy(rs2_busy),
    .lock_valid(lock_valid),
    .lock_addr(lock_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int        ack_cyc;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a write from IDLE. The ack is due in the next cycle.
  task automatic start_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    exp_t e;
    reg_wr_addr       = a;
    reg_wr_data       = d;
    reg_wr_data_valid = 1'b1;
    e.ack_cyc = cyc + 1;
    e.addr    = a;
    q.push_back(e);
  endtask

  // Monitor: every observed ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reg_wr_ack === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack at cycle %0d want no ack", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("ack_cycle_x%0d", e.addr), 32'(cyc), 32'(e.ack_cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    reg_wr_data = '0;
    reg_wr_addr = '0;
    reg_wr_data_valid = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    lock_valid = 1'b0;
    lock_addr = '0;

    // 1. reset state
    repeat (3) tick();
    chk("reset_ack", 32'(reg_wr_ack), 32'd0);
    for (int a = 0; a < NR; a++) begin
      rs1_addr = AW'(a);
      rs2_addr = AW'(a);
      #1;
      chk($sformatf("reset_x%0d", a), rs1_data | rs2_data | 32'({rs1_busy, rs2_busy}), 32'd0);
    end
    reset = 1'b0;
    tick();

    // 2. single write x5 = 2
    start_write(5'd5, 32'h2);
    tick();
    reg_wr_data_valid = 1'b0;
    tick();
    rs1_addr = 5'd5;
    #1 chk("read_x5", rs1_data, 32'h2);
    chk("x5_not_busy", 32'(rs1_busy), 32'd0);

    // 3. valid held across the ACK slot: two acks, two cycles apart
    reg_wr_addr = 5'd6;
    reg_wr_data = 32'd7;
    reg_wr_data_valid = 1'b1;
    q.push_back('{cyc + 1, 5'd6});
    q.push_back('{cyc + 3, 5'd6});
    repeat (4) tick();
    reg_wr_data_valid = 1'b0;
    rs1_addr = 5'd6;
    #1 chk("read_x6", rs1_data, 32'd7);

    // 4. write to x0 is acked but discarded, and x0 is never forwarded
    start_write(5'd0, 32'hFFFF_FFFF);
    rs1_addr = 5'd0;
    #1 chk("x0_no_bypass", rs1_data, 32'd0);
    tick();
    reg_wr_data_valid = 1'b0;
    tick();
    chk("read_x0", rs1_data, 32'd0);

    // 5. lock x9, the x0 lock is ignored, then a commit clears busy
    lock_valid = 1'b1;
    lock_addr = 5'd9;
    tick();
    lock_valid = 1'b0;
    rs2_addr = 5'd9;
    #1 chk("busy_x9", 32'(rs2_busy), 32'd1);
    lock_valid = 1'b1;
    lock_addr = 5'd0;
    tick();
    lock_valid = 1'b0;
    rs2_addr = 5'd0;
    #1 chk("busy_x0", 32'(rs2_busy), 32'd0);
    rs2_addr = 5'd9;
    start_write(5'd9, 32'h4);
    #1 chk("bypass_x9", rs2_data, 32'h4);
    chk("busy_x9_pre_commit", 32'(rs2_busy), 32'd1);
    tick();
    reg_wr_data_valid = 1'b0;
    #1 chk("busy_x9_cleared", 32'(rs2_busy), 32'd0);
    chk("read_x9", rs2_data, 32'h4);
    tick();

    // 6. same-edge lock and commit on x3, and bypass while IDLE
    rs1_addr = 5'd3;
    start_write(5'd3, 32'hA);
    lock_valid = 1'b1;
    lock_addr = 5'd3;
    #1 chk("bypass_x3", rs1_data, 32'hA);
    tick();
    lock_valid = 1'b0;
    reg_wr_data = 32'hB;  // still valid in the ACK slot: must be ignored
    #1 chk("no_bypass_in_ack", rs1_data, 32'hA);
    chk("busy_x3_kept", 32'(rs1_busy), 32'd1);
    reg_wr_data_valid = 1'b0;
    tick();
    chk("read_x3", rs1_data, 32'hA);
    chk("busy_x3_still", 32'(rs1_busy), 32'd1);
    start_write(5'd3, 32'h11);
    tick();
    reg_wr_data_valid = 1'b0;
    tick();
    chk("read_x3_again", rs1_data, 32'h11);
    chk("busy_x3_cleared", 32'(rs1_busy), 32'd0);

    // reset on the same edge as a request: no write, no ack
    rs1_addr = 5'd10;
    rs2_addr = 5'd5;
    reg_wr_addr = 5'd10;
    reg_wr_data = 32'h5;
    reg_wr_data_valid = 1'b1;
    reset = 1'b1;
    tick();
    reg_wr_data_valid = 1'b0;
    reset = 1'b0;
    #1 chk("reset_wins_x10", rs1_data, 32'd0);
    chk("reset_clears_x5", rs2_data, 32'd0);
    chk("reset_ack_low", 32'(reg_wr_ack), 32'd0);
    repeat (2) tick();

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("queue_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
